// File: rtl/icap_seq_pkg.sv
// Shared types, IPROG command words and helpers for the ICAP reboot sequencer.
package icap_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [15:0] DUMMY     = 16'hFFFF;
  localparam logic [15:0] SYNC0     = 16'hAA99;
  localparam logic [15:0] SYNC1     = 16'h5566;
  localparam logic [15:0] WR_GEN1   = 16'h3261;
  localparam logic [15:0] WR_GEN2   = 16'h3281;
  localparam logic [15:0] WR_CMD    = 16'h30A1;
  localparam logic [15:0] CMD_IPROG = 16'h000E;
  localparam logic [15:0] NOOP      = 16'h2000;

  localparam int SEQ_LEN = 10;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] dat;
  } wb_req_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/icap_seq_rom.sv
// IPROG word table: 10 fixed/address-derived 16-bit words indexed 0..9.
module icap_seq_rom
  import icap_seq_pkg::*;
#(
  parameter logic [7:0] OPCODE = 8'h0B
) (
  input  logic [3:0]  idx,
  input  logic [23:0] addr,
  output logic [15:0] word
);

  always_comb begin
    word = NOOP;
    case (idx)
      4'd0:    word = DUMMY;
      4'd1:    word = SYNC0;
      4'd2:    word = SYNC1;
      4'd3:    word = WR_GEN1;
      4'd4:    word = addr[15:0];
      4'd5:    word = WR_GEN2;
      4'd6:    word = {OPCODE, addr[23:16]};
      4'd7:    word = WR_CMD;
      4'd8:    word = CMD_IPROG;
      4'd9:    word = NOOP;
      default: word = NOOP;
    endcase
  end

endmodule

// File: rtl/icap_reboot_seq.sv
// Wishbone master streaming the S3A IPROG sequence byte-wise into the ICAP slave.
// Optional per-byte ack timeout enabled by defining ICAP_SEQ_TIMEOUT_EN.
module icap_reboot_seq
  import icap_seq_pkg::*;
#(
  parameter logic [7:0] OPCODE  = 8'h0B,
  parameter bit         BITSWAP = 1'b1,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [23:0] boot_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i
);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic        bsel;
  logic [23:0] addr_q;
  logic [15:0] word;
  logic [7:0]  cur_byte;
  logic        last;
  logic        timeout_hit;
  wb_req_t     req;

  icap_seq_rom #(.OPCODE(OPCODE)) u_rom (
    .idx  (idx),
    .addr (addr_q),
    .word (word)
  );

  assign cur_byte = bsel ? word[7:0] : word[15:8];
  assign last     = (idx == 4'(SEQ_LEN - 1)) && bsel;

`ifdef ICAP_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
  logic        error_q;

  assign timeout_hit = (state == S_REQ) && !wb_ack_i && (to_cnt == TO_LAST);

  // to_cnt is zero whenever REQ is entered since every other state clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      to_cnt <= (state == S_REQ) ? to_cnt + 16'd1 : 16'd0;
      if (state == S_IDLE && go) error_q <= 1'b0;
      else if (timeout_hit)      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign error          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go) state_nxt = S_REQ;
      S_REQ: begin
        if (wb_ack_i)         state_nxt = S_GAP;
        else if (timeout_hit) state_nxt = S_FIN;
      end
      S_GAP:   state_nxt = last ? S_FIN : S_REQ;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address is captured once per run so later boot_addr changes cannot leak in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      bsel   <= 1'b0;
      addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          addr_q <= boot_addr;
          idx    <= '0;
          bsel   <= 1'b0;
        end
        S_GAP: if (!last) begin
          bsel <= ~bsel;
          if (bsel) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req = '0;
    if (state == S_REQ) begin
      req.cyc = 1'b1;
      req.stb = 1'b1;
      req.we  = 1'b1;
      req.dat = {24'h0, (BITSWAP ? bit_rev8(cur_byte) : cur_byte)};
    end
  end

  assign wb_cyc_o = req.cyc;
  assign wb_stb_o = req.stb;
  assign wb_we_o  = req.we;
  assign wb_dat_o = req.dat;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);

endmodule
